vic_wb_buffer: RTL and testbench
================================

Name: vic_wb_buffer

Overview:
- Write-back buffer at the drain end of the victim cache.
- Accepts lines fired out of vic_cache (fired_valid/fired_victim plus set index) and queues the dirty ones in a small FIFO.
- Writes each queued line to memory with BUS_STORE over the shared proc2mem/mem2proc interface, via the memory arbiter grant.
- Provides a CAM lookup so a dcache miss can be served from a line still waiting to be written back.

Parameters:
DEPTH, 4, number of buffered lines (power of 2, at least 2)
PTR_BITS, $clog2(DEPTH), width of the head and tail pointers

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
fired_valid  in  1  vic_cache is evicting a line this cycle
fired_victim  in  CACHE_LINE_T  evicted line {valid, dirty, tag, data[63:0]}
fired_set_index  in  NUM_SET_BITS  set index of the evicted line
mem_grant  in  1  arbiter grants the memory port to this block this cycle
mem2proc_response  in  4  nonzero means the memory accepted the request
lookup_valid  in  1  dcache miss probe
lookup_set_index  in  NUM_SET_BITS  probe set index
lookup_tag  in  NUM_TAG_BITS  probe tag
proc2mem_command  out  2  BUS_NONE or BUS_STORE
proc2mem_addr  out  64  {zero pad, tag, set_index, 3'b000}
proc2mem_data  out  64  data of the head line
lookup_hit  out  1  probe matched a buffered line
lookup_data  out  64  data of the matching line
full  out  1  count == DEPTH (vic_cache must not fire)
empty  out  1  count == 0
wb_count  out  PTR_BITS+1  number of occupied entries

Behaviour:
- Storage and state:
  - Circular FIFO of DEPTH entries; each entry holds {valid, tag, set_index, data}.
  - Registered head, tail and count.
  - FSM with states IDLE and STORE.
- Reset (synchronous, at a clock edge with reset=1):
  - All entries invalid; head = tail = count = 0; FSM = IDLE.
  - Outputs: proc2mem_command=BUS_NONE, proc2mem_addr=0, proc2mem_data=0, full=0, empty=1, lookup_hit=0, lookup_data=0, wb_count=0.
  - Reset has priority over every other event, including mid-store; any in-flight line is discarded.
- Enqueue condition: fired_valid && fired_victim.valid && fired_victim.dirty.
  - Clean or invalid victims are dropped with no state change.
- Coalescing: if the incoming line's {set_index, tag} matches a valid entry, that entry's data is overwritten in place.
  - Exception: when the matching entry is the head being accepted this same cycle, a new entry is allocated instead.
  - Without a match, the line is written at tail; tail advances (wrapping DEPTH-1 -> 0) and count increments.
- Full boundary:
  - full is decoded from the registered count.
  - Allocation while full is ignored (no state change) even if a dequeue happens the same cycle.
  - Coalescing while full is still performed.
- FSM:
  - IDLE: command = BUS_NONE. Go to STORE the next cycle if count != 0, or if an enqueue occurs this cycle.
  - STORE: command = BUS_STORE, with addr/data taken combinationally from the head.
  - STORE accept: mem_grant && mem2proc_response != 0. On accept, invalidate head, advance head (wrap), decrement count. Next state is IDLE if the post-update count is 0, else STORE (back-to-back stores, no bubble).
  - STORE with no accept: hold, and keep addr/data stable.
- Simultaneous enqueue and dequeue: count is unchanged; both pointers advance.
- Latency:
  - A line fired in cycle N is first driven as BUS_STORE in cycle N+1 when the buffer was empty.
  - Minimum residency is 1 cycle.
- Lookup:
  - Combinational over registered entries only; a same-cycle enqueue is not visible.
  - Hit requires lookup_valid && a valid entry matching both set_index and tag.
  - After coalescing at most one entry can match. lookup_data is 0 when there is no hit.
  - The head being accepted this cycle still hits this cycle.
- Address: proc2mem_addr = {zero extension, tag, set_index, 3'b000}, 64 bits wide.

Decomposition:
- Shared package (sys_defs): CACHE_LINE_T, NUM_SET_BITS, NUM_TAG_BITS, BUS_NONE/BUS_STORE encodings, and a WB_ENTRY_T typedef {valid, tag, set_index, data}.
- One natural sub-module: wb_cam, a parameterised DEPTH-way match over entries returning a one-hot match vector. It is used both for lookup and for coalesce detection.
- The FSM and pointers stay in the top module.

Test Plan:
- Reset: assert reset for 1 cycle -> empty=1, full=0, wb_count=0, proc2mem_command=BUS_NONE, lookup_hit=0.
- Single store: fire dirty {tag=5, set=2, data=64'hAB}, then mem_grant=1 with response=1 in the next cycle -> BUS_STORE addr=(5<<(NUM_SET_BITS+3))|(2<<3), data=64'hAB; one cycle later empty=1 and the FSM is back in IDLE.
- Fill and backpressure: fire 5 distinct dirty lines with no grant -> full=1 after 4, the 5th is ignored, wb_count=4; then grant 4 consecutive cycles -> stores leave in FIFO order and tail wraps to 0.
- Clean drop and coalesce: fire a clean line -> wb_count unchanged; fire the same {tag,set} twice with data 1 then 2 -> wb_count=1 and the stored data is 2.
- Lookup: with {tag=7, set=1, data=64'h55} buffered, probe that address -> lookup_hit=1, lookup_data=64'h55; probe tag=8 -> hit=0, data=0.
- Corner cases: while the head is being accepted, fire a line with the same address -> a new entry is allocated and wb_count is unchanged. Assert reset mid-STORE -> next cycle command=BUS_NONE and empty=1.

Source files
------------

// File: rtl/vic_wb_buffer_pkg.sv
// Shared types for the victim-cache write-back buffer: cache line and buffer entry
// layouts, bus command encodings and the line-address helper.
package vic_wb_buffer_pkg;

   localparam int NUM_SET_BITS = 4;
   localparam int NUM_TAG_BITS = 13;
   localparam int ADDR_PAD_BITS = 64 - NUM_TAG_BITS - NUM_SET_BITS - 3;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'b00,
      BUS_LOAD  = 2'b01,
      BUS_STORE = 2'b10
   } BUS_COMMAND;

   typedef struct packed {
      logic                    valid;
      logic                    dirty;
      logic [NUM_TAG_BITS-1:0] tag;
      logic [63:0]             data;
   } CACHE_LINE_T;

   typedef struct packed {
      logic                    valid;
      logic [NUM_TAG_BITS-1:0] tag;
      logic [NUM_SET_BITS-1:0] set_index;
      logic [63:0]             data;
   } WB_ENTRY_T;

   typedef enum logic {
      WB_IDLE  = 1'b0,
      WB_STORE = 1'b1
   } WB_STATE_T;

   function automatic logic [63:0] wb_addr(input logic [NUM_TAG_BITS-1:0] tag,
                                           input logic [NUM_SET_BITS-1:0] set_index);
      return {{ADDR_PAD_BITS{1'b0}}, tag, set_index, 3'b000};
   endfunction

endpackage

// File: rtl/vic_wb_buffer_cam.sv
// DEPTH-way associative match of {set_index, tag} against the buffered entries;
// returns a one-hot (or empty) match vector.
module vic_wb_buffer_cam
   import vic_wb_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0]              entry_valid,
   input  logic [DEPTH*NUM_TAG_BITS-1:0] entry_tags,
   input  logic [DEPTH*NUM_SET_BITS-1:0] entry_sets,
   input  logic [NUM_TAG_BITS-1:0]       query_tag,
   input  logic [NUM_SET_BITS-1:0]       query_set_index,
   output logic [DEPTH-1:0]              match
);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_way
      assign match[gi] = entry_valid[gi]
                      && (entry_tags[gi*NUM_TAG_BITS +: NUM_TAG_BITS] == query_tag)
                      && (entry_sets[gi*NUM_SET_BITS +: NUM_SET_BITS] == query_set_index);
   end

endmodule

// File: rtl/vic_wb_buffer.sv
// Write-back buffer behind the victim cache: queues dirty evictions, drains them to
// memory with BUS_STORE, coalesces repeat evictions and serves dcache-miss probes.
module vic_wb_buffer
   import vic_wb_buffer_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int PTR_BITS = $clog2(DEPTH)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    fired_valid,
   input  CACHE_LINE_T             fired_victim,
   input  logic [NUM_SET_BITS-1:0] fired_set_index,
   input  logic                    mem_grant,
   input  logic [3:0]              mem2proc_response,
   input  logic                    lookup_valid,
   input  logic [NUM_SET_BITS-1:0] lookup_set_index,
   input  logic [NUM_TAG_BITS-1:0] lookup_tag,
   output logic [1:0]              proc2mem_command,
   output logic [63:0]             proc2mem_addr,
   output logic [63:0]             proc2mem_data,
   output logic                    lookup_hit,
   output logic [63:0]             lookup_data,
   output logic                    full,
   output logic                    empty,
   output logic [PTR_BITS:0]       wb_count
);

   WB_ENTRY_T             entries_reg [DEPTH];
   logic [PTR_BITS-1:0]   head_reg, tail_reg;
   logic [PTR_BITS:0]     count_reg, count_next;
   WB_STATE_T             state_reg, state_next;

   logic [DEPTH-1:0]              entry_valid;
   logic [DEPTH*NUM_TAG_BITS-1:0] entry_tags;
   logic [DEPTH*NUM_SET_BITS-1:0] entry_sets;
   logic [DEPTH-1:0]              lookup_match, fired_match, coalesce_match, head_onehot;
   logic                          enq, accept, coalesce, alloc;
   WB_ENTRY_T                     head_entry;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign entry_valid[gi] = entries_reg[gi].valid;
      assign entry_tags[gi*NUM_TAG_BITS +: NUM_TAG_BITS] = entries_reg[gi].tag;
      assign entry_sets[gi*NUM_SET_BITS +: NUM_SET_BITS] = entries_reg[gi].set_index;
   end

   vic_wb_buffer_cam #(.DEPTH(DEPTH)) u_lookup_cam (
      .entry_valid     (entry_valid),
      .entry_tags      (entry_tags),
      .entry_sets      (entry_sets),
      .query_tag       (lookup_tag),
      .query_set_index (lookup_set_index),
      .match           (lookup_match)
   );

   vic_wb_buffer_cam #(.DEPTH(DEPTH)) u_coalesce_cam (
      .entry_valid     (entry_valid),
      .entry_tags      (entry_tags),
      .entry_sets      (entry_sets),
      .query_tag       (fired_victim.tag),
      .query_set_index (fired_set_index),
      .match           (fired_match)
   );

   assign head_entry  = entries_reg[head_reg];
   assign enq         = fired_valid && fired_victim.valid && fired_victim.dirty;
   assign accept      = (state_reg == WB_STORE) && mem_grant && (mem2proc_response != 4'd0);
   assign full        = (count_reg == (PTR_BITS+1)'(DEPTH));
   assign empty       = (count_reg == '0);
   assign wb_count    = count_reg;

   // The head leaving this cycle must not absorb new data, or that data would be lost.
   assign head_onehot    = accept ? ({{(DEPTH-1){1'b0}}, 1'b1} << head_reg) : '0;
   assign coalesce_match = fired_match & ~head_onehot;
   assign coalesce       = enq && (coalesce_match != '0);
   assign alloc          = enq && !coalesce && !full;

   always_comb begin
      count_next = count_reg;
      case ({alloc, accept})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) entries_reg[i] <= '0;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (accept) begin
            entries_reg[head_reg].valid <= 1'b0;
            head_reg                    <= head_reg + 1'b1;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (coalesce && coalesce_match[i]) entries_reg[i].data <= fired_victim.data;
         end
         if (alloc) begin
            entries_reg[tail_reg] <= '{valid: 1'b1, tag: fired_victim.tag,
                                       set_index: fired_set_index, data: fired_victim.data};
            tail_reg              <= tail_reg + 1'b1;
         end
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state_reg <= WB_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         WB_IDLE:  if (count_reg != '0 || enq) state_next = WB_STORE;
         WB_STORE: if (accept && count_next == '0) state_next = WB_IDLE;
         default:  state_next = WB_IDLE;
      endcase
   end

   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      if (state_reg == WB_STORE) begin
         proc2mem_command = BUS_STORE;
         proc2mem_addr    = wb_addr(head_entry.tag, head_entry.set_index);
         proc2mem_data    = head_entry.data;
      end
   end

   // Probes see registered entries only; coalescing guarantees at most one match.
   always_comb begin
      lookup_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (lookup_valid && lookup_match[i]) lookup_data = lookup_data | entries_reg[i].data;
      end
   end
   assign lookup_hit = lookup_valid && (lookup_match != '0);

endmodule

// File: tb/tb_vic_wb_buffer.sv
// Scoreboard bench for vic_wb_buffer: a queue-based line model predicts per-cycle
// status and the order/content of stores; a monitor compares against the DUT.
module tb_vic_wb_buffer;
   import vic_wb_buffer_pkg::*;

   localparam int DEPTH    = 4;
   localparam int PTR_BITS = 2;

   logic                    clock;
   logic                    reset;
   logic                    fired_valid;
   CACHE_LINE_T             fired_victim;
   logic [NUM_SET_BITS-1:0] fired_set_index;
   logic                    mem_grant;
   logic [3:0]              mem2proc_response;
   logic                    lookup_valid;
   logic [NUM_SET_BITS-1:0] lookup_set_index;
   logic [NUM_TAG_BITS-1:0] lookup_tag;
   logic [1:0]              proc2mem_command;
   logic [63:0]             proc2mem_addr;
   logic [63:0]             proc2mem_data;
   logic                    lookup_hit;
   logic [63:0]             lookup_data;
   logic                    full;
   logic                    empty;
   logic [PTR_BITS:0]       wb_count;

   vic_wb_buffer #(.DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) dut (
      .clock             (clock),
      .reset             (reset),
      .fired_valid       (fired_valid),
      .fired_victim      (fired_victim),
      .fired_set_index   (fired_set_index),
      .mem_grant         (mem_grant),
      .mem2proc_response (mem2proc_response),
      .lookup_valid      (lookup_valid),
      .lookup_set_index  (lookup_set_index),
      .lookup_tag        (lookup_tag),
      .proc2mem_command  (proc2mem_command),
      .proc2mem_addr     (proc2mem_addr),
      .proc2mem_data     (proc2mem_data),
      .lookup_hit        (lookup_hit),
      .lookup_data       (lookup_data),
      .full              (full),
      .empty             (empty),
      .wb_count          (wb_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit          rst;
      bit          fv;
      bit          fvalid;
      bit          fdirty;
      int          ftag;
      int          fset;
      logic [63:0] fdata;
      bit          grant;
      logic [3:0]  resp;
      bit          lv;
      int          ltag;
      int          lset;
   } stim_t;

   typedef struct {
      bit          chk;
      logic [1:0]  cmd;
      logic [63:0] addr;
      logic [63:0] data;
      int          count;
      logic        full;
      logic        empty;
      logic        hit;
      logic [63:0] ldata;
   } status_t;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
   } store_t;

   typedef struct {
      int          tag;
      int          set;
      logic [63:0] data;
   } line_t;

   status_t status_q[$];
   store_t  store_q[$];
   line_t   model_q[$];
   int      checks   = 0;
   int      failures = 0;
   bit      driving_done = 0;

   function automatic logic [63:0] line_addr(input int tag, input int set);
      return (64'(tag) << (NUM_SET_BITS + 3)) | (64'(set) << 3);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t idle_stim();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   function automatic stim_t fire_stim(input int tag, input int set, input logic [63:0] data,
                                       input bit dirty);
      stim_t s;
      s        = idle_stim();
      s.fv     = 1;
      s.fvalid = 1;
      s.fdirty = dirty;
      s.ftag   = tag;
      s.fset   = set;
      s.fdata  = data;
      return s;
   endfunction

   // Drive one cycle and advance the reference model across the coming clock edge.
   task automatic step(input stim_t st);
      status_t s;
      bit      acc;
      bit      found;
      int      size_before;
      @(negedge clock);
      reset                = st.rst;
      fired_valid          = st.fv;
      fired_victim.valid   = st.fvalid;
      fired_victim.dirty   = st.fdirty;
      fired_victim.tag     = NUM_TAG_BITS'(st.ftag);
      fired_victim.data    = st.fdata;
      fired_set_index      = NUM_SET_BITS'(st.fset);
      mem_grant            = st.grant;
      mem2proc_response    = st.resp;
      lookup_valid         = st.lv;
      lookup_tag           = NUM_TAG_BITS'(st.ltag);
      lookup_set_index     = NUM_SET_BITS'(st.lset);

      s = '{default: 0};
      if (st.rst) begin
         status_q.push_back(s);
         model_q.delete();
         return;
      end
      size_before = model_q.size();
      s.chk   = 1;
      s.count = size_before;
      s.full  = (size_before == DEPTH);
      s.empty = (size_before == 0);
      s.cmd   = (size_before != 0) ? BUS_STORE : BUS_NONE;
      s.addr  = (size_before != 0) ? line_addr(model_q[0].tag, model_q[0].set) : 64'd0;
      s.data  = (size_before != 0) ? model_q[0].data : 64'd0;
      if (st.lv) begin
         foreach (model_q[i]) begin
            if (model_q[i].tag == st.ltag && model_q[i].set == st.lset) begin
               s.hit   = 1;
               s.ldata = model_q[i].data;
            end
         end
      end
      status_q.push_back(s);

      acc = (size_before != 0) && st.grant && (st.resp != 4'd0);
      if (acc) begin
         store_q.push_back('{addr: s.addr, data: s.data});
         void'(model_q.pop_front());
      end
      if (st.fv && st.fvalid && st.fdirty) begin
         found = 0;
         foreach (model_q[i]) begin
            if (model_q[i].tag == st.ftag && model_q[i].set == st.fset) begin
               model_q[i].data = st.fdata;
               found = 1;
            end
         end
         if (!found && size_before < DEPTH)
            model_q.push_back('{tag: st.ftag, set: st.fset, data: st.fdata});
      end
   endtask

   // Monitor: per-cycle status, plus every store the DUT completes against the scoreboard.
   initial begin
      status_t s;
      store_t  e;
      forever begin
         @(negedge clock);
         #2;
         if (status_q.size() > 0) begin
            s = status_q.pop_front();
            if (s.chk) begin
               check("command",     64'(proc2mem_command), 64'(s.cmd));
               check("addr",        proc2mem_addr, s.addr);
               check("data",        proc2mem_data, s.data);
               check("wb_count",    64'(wb_count), 64'(s.count));
               check("full",        64'(full), 64'(s.full));
               check("empty",       64'(empty), 64'(s.empty));
               check("lookup_hit",  64'(lookup_hit), 64'(s.hit));
               check("lookup_data", lookup_data, s.ldata);
            end
         end
         if (!reset && proc2mem_command == BUS_STORE && mem_grant && mem2proc_response != 4'd0) begin
            if (store_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_store actual=%0h required=none at %0t", proc2mem_addr, $time);
            end else begin
               e = store_q.pop_front();
               $display("store addr=%0h data=%0h", proc2mem_addr, proc2mem_data);
               check("store_addr", proc2mem_addr, e.addr);
               check("store_data", proc2mem_data, e.data);
            end
         end
      end
   end

   initial begin
      stim_t st;
      reset = 1'b1;
      fired_valid = 1'b0;
      fired_victim = '0;
      fired_set_index = '0;
      mem_grant = 1'b0;
      mem2proc_response = '0;
      lookup_valid = 1'b0;
      lookup_set_index = '0;
      lookup_tag = '0;

      st = idle_stim(); st.rst = 1;
      step(st);
      step(st);
      step(idle_stim());

      // single store
      step(fire_stim(5, 2, 64'hAB, 1));
      st = idle_stim(); st.grant = 1; st.resp = 4'd1;
      step(st);
      step(idle_stim());

      // fill, backpressure, then drain in order across the wrap
      for (int i = 0; i < 5; i++) step(fire_stim(10 + i, 3, 64'h100 + 64'(i), 1));
      step(idle_stim());
      for (int i = 0; i < 4; i++) step(st);
      step(idle_stim());

      // clean drop, coalescing, probe of the coalesced line
      step(fire_stim(9, 6, 64'hDEAD, 0));
      step(fire_stim(9, 6, 64'd1, 1));
      step(fire_stim(9, 6, 64'd2, 1));
      st = idle_stim(); st.lv = 1; st.ltag = 9; st.lset = 6;
      step(st);
      st = idle_stim(); st.grant = 1; st.resp = 4'd1;
      step(st);
      step(idle_stim());

      // lookup hit and miss
      step(fire_stim(7, 1, 64'h55, 1));
      st = idle_stim(); st.lv = 1; st.ltag = 7; st.lset = 1;
      step(st);
      st.ltag = 8;
      step(st);
      st = idle_stim(); st.grant = 1; st.resp = 4'd1;
      step(st);
      step(idle_stim());

      // same address fired while its head is being accepted allocates a new entry
      step(fire_stim(3, 3, 64'hA, 1));
      st = fire_stim(3, 3, 64'hB, 1); st.grant = 1; st.resp = 4'd2; st.lv = 1; st.ltag = 3; st.lset = 3;
      step(st);
      st = idle_stim(); st.grant = 1; st.resp = 4'd4;
      step(st);
      step(idle_stim());

      // reset during STORE discards the in-flight line
      step(fire_stim(4, 4, 64'hC0FFEE, 1));
      step(fire_stim(6, 4, 64'hBEEF, 1));
      st = idle_stim(); st.rst = 1;
      step(st);
      step(idle_stim());

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         st        = idle_stim();
         st.fv     = ($urandom_range(0, 99) < 60);
         st.fvalid = ($urandom_range(0, 99) < 90);
         st.fdirty = ($urandom_range(0, 99) < 75);
         st.ftag   = int'($urandom_range(0, 3));
         st.fset   = int'($urandom_range(0, 3));
         st.fdata  = {$urandom, $urandom};
         st.grant  = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 35 : 80));
         st.resp   = 4'($urandom_range(0, 3));
         st.lv     = ($urandom_range(0, 99) < 50);
         st.ltag   = int'($urandom_range(0, 3));
         st.lset   = int'($urandom_range(0, 3));
         st.rst    = ($urandom_range(0, 499) == 0);
         if (st.rst) st.grant = 0;
         step(st);
      end

      st = idle_stim(); st.grant = 1; st.resp = 4'd1;
      for (int i = 0; i < 8; i++) step(st);
      step(idle_stim());
      driving_done = 1;
      @(negedge clock);
      @(negedge clock);
      check("scoreboard_drained", 64'(store_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
